cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through data-cache controller for the pipelined RV32I core. It sits between the memory stage and main memory. It owns the valid/tag/data arrays (8 one-word lines) and sequences lookup, read-miss refill, write-through and flush. It stalls the pipeline while memory traffic is outstanding and keeps saturating hit/miss counters.

## Interface
Parameters:
- SET_WIDTH, 3: index bits; 2**SET_WIDTH lines of one 32-bit word each.
- CNT_WIDTH, 16: width of the hit/miss counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory-stage access request; held until cpu_stall is low.
- cpu_we  in  1  1 = store, 0 = load; qualifies cpu_req.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_req & !cpu_we & !cpu_stall.
- cpu_stall  out  1  freezes the pipeline (combinational).
- flush  in  1  one-cycle pulse: invalidate all lines.
- mem_req  out  1  main-memory request (registered).
- mem_we  out  1  1 = write-through, 0 = refill read.
- mem_addr  out  32  {latched addr[31:2], 2'b00}.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  refill data, sampled on the mem_ack cycle.
- mem_ack  in  1  one-cycle completion strobe; ignored while mem_req = 0.
- hit_cnt  out  CNT_WIDTH  load hits, saturating.
- miss_cnt  out  CNT_WIDTH  load misses, saturating.

## Operation
- Address split: index = addr[SET_WIDTH+1:2], tag = addr[31:SET_WIDTH+2].
- hit = valid[index] & (tag_arr[index] == tag).
- States:
  - IDLE (reset state).
  - REFILL.
  - WRITE.
  - DONE.
- From IDLE, with cpu_req and no flush:
  - Load hit: cpu_rdata = data_arr[index]. No state change.
  - Load miss: latch the address, go to REFILL, increment miss_cnt.
  - Store (hit or miss): latch addr, wdata and the hit flag, go to WRITE.
- REFILL:
  - mem_req=1, mem_we=0.
  - On mem_ack: data_arr[index]=mem_rdata, tag written, valid=1, go to IDLE.
  - The replayed load then hits.
- WRITE:
  - mem_req=1, mem_we=1.
  - On mem_ack: if the latched hit flag is set, data_arr[index]=wdata. Stores never allocate on a miss.
  - Go to DONE.
- DONE: cpu_stall=0 so the store retires. cpu_req is ignored. Next state is IDLE unconditionally.
- cpu_stall = (IDLE & cpu_req & (cpu_we | !hit | flush_eff)) | REFILL | WRITE.
- cpu_rdata = 0 whenever the load is not a hit.
- Flush:
  - flush_eff = flush | flush_pend.
  - In IDLE, flush_eff clears all valid bits at the edge and clears flush_pend. A simultaneous cpu_req is stalled that cycle and re-evaluated next cycle, where it misses.
  - A flush pulse outside IDLE sets flush_pend. It is applied on the first IDLE cycle.
- hit_cnt:
  - Increments on an IDLE load hit with cpu_stall=0.
  - Does not increment on the first IDLE cycle after REFILL (register refill_just_done), so a miss is not also counted as a hit.
- Both counters saturate at all-ones. Stores are not counted.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, all valid=0, mem_req=0, mem_we=0, flush_pend=0, refill_just_done=0, hit_cnt=0, miss_cnt=0.
  - mem_addr and mem_wdata are 0.
  - Tag and data arrays are not reset.
- Load hit: 0 stall cycles; data is combinational in the request cycle.
- Load miss: stalled in the request cycle. mem_req rises at the next edge. With mem_ack N cycles later, the load completes in the IDLE cycle after ack, for a total stall of N+2 cycles.
- Store: stalled in the request cycle plus the WRITE cycles. It retires in DONE. Back-to-back accesses are separated by at least one cycle.
- mem_req, mem_we and mem_addr are stable from entry to REFILL/WRITE until the ack edge. mem_req drops at the ack edge.
- Reset mid-REFILL or mid-WRITE: the transaction is abandoned, mem_req drops immediately and no array is written.

## Test plan
- Reset, then load 0x0000_0040 → miss. mem_req=1, mem_addr=0x40 next cycle. Ack with 0xDEADBEEF after 3 cycles → IDLE cycle, cpu_rdata=0xDEADBEEF, stall=0, miss_cnt=1, hit_cnt=0.
- Reload 0x40 → hit in the request cycle, 0 stall, hit_cnt=1. Load 0x60 (same index 0, new tag) → miss and refill. A subsequent load of 0x40 misses again.
- Store 0x1234_5678 to 0x40 (line valid) → WRITE, mem_we=1, mem_wdata=0x12345678. Ack → DONE with stall=0. Load 0x40 → hit returning 0x12345678.
- Store to 0x84 while the line is invalid → write-through only. Load 0x84 → miss (no allocate).
- Pulse flush during REFILL → line filled, flush_pend=1. In the first IDLE cycle a load to the same address stalls, all valids clear, and it then misses.
- Force hit_cnt to 0xFFFF, then perform a load hit → hit_cnt stays 0xFFFF. Assert rst_n=0 mid-WRITE → mem_req=0 immediately, state=IDLE.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through data cache controller with one-word
// lines. Sequences lookup, read-miss refill, write-through and flush, stalls the
// pipeline while memory traffic is outstanding, and keeps saturating counters.
//
// state  | meaning
// IDLE   | lookup; load hits return data with no stall, flushes are applied
// REFILL | read-miss line fill from main memory, waiting for mem_ack
// WRITE  | write-through of a store to main memory, waiting for mem_ack
// DONE   | store retires (stall released); cpu_req ignored for this cycle
module cache_ctrl #(
  parameter int SET_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 flush,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int LINES = 1 << SET_WIDTH;
  localparam int TAG_W = 30 - SET_WIDTH;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_arr  [LINES];
  logic [31:0]            data_arr [LINES];
  logic                   lat_hit;
  logic                   flush_pend;
  logic                   refill_just_done;

  logic [SET_WIDTH-1:0]   index;
  logic [TAG_W-1:0]       tag;
  logic [SET_WIDTH-1:0]   lat_index;
  logic [TAG_W-1:0]       lat_tag;
  logic                   hit;
  logic                   flush_eff;
  logic                   refill_we;
  logic                   store_we;
  logic                   unused_addr_lsb;

  // Byte offset is irrelevant for word accesses.
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign index     = cpu_addr[SET_WIDTH+1:2];
  assign tag       = cpu_addr[31:SET_WIDTH+2];
  // The latched memory address doubles as the pending line's index/tag.
  assign lat_index = mem_addr[SET_WIDTH+1:2];
  assign lat_tag   = mem_addr[31:SET_WIDTH+2];

  assign hit       = valid[index] && (tag_arr[index] == tag);
  assign flush_eff = flush | flush_pend;
  assign cpu_rdata = hit ? data_arr[index] : 32'h0;

  assign cpu_stall = ((state == IDLE) && cpu_req && (cpu_we || !hit || flush_eff))
                     || (state == REFILL) || (state == WRITE);

  // Array writes only happen on an ack edge; reset forces IDLE so an abandoned
  // transaction can never write.
  assign refill_we = (state == REFILL) && mem_ack;
  assign store_we  = (state == WRITE) && mem_ack && lat_hit;

  // Tag/data arrays: no reset, qualified by the valid bits instead.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_arr[lat_index] <= mem_rdata;
      tag_arr[lat_index]  <= lat_tag;
    end else if (store_we) begin
      data_arr[lat_index] <= mem_wdata;
    end
  end

  // Controller FSM, memory interface registers, valid bits and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      valid            <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= 32'h0;
      mem_wdata        <= 32'h0;
      lat_hit          <= 1'b0;
      flush_pend       <= 1'b0;
      refill_just_done <= 1'b0;
      hit_cnt          <= '0;
      miss_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          refill_just_done <= 1'b0;
          if (flush_eff) begin
            // Any simultaneous request is stalled and re-evaluated next cycle.
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req) begin
            if (!cpu_we) begin
              if (hit) begin
                // The replayed load after a refill was already counted as a miss.
                if (!refill_just_done && (hit_cnt != '1))
                  hit_cnt <= hit_cnt + CNT_WIDTH'(1);
              end else begin
                mem_addr <= {cpu_addr[31:2], 2'b00};
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                state    <= REFILL;
                if (miss_cnt != '1)
                  miss_cnt <= miss_cnt + CNT_WIDTH'(1);
              end
            end else begin
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_wdata <= cpu_wdata;
              lat_hit   <= hit;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        REFILL: begin
          if (flush)
            flush_pend <= 1'b1;
          if (mem_ack) begin
            valid[lat_index] <= 1'b1;
            mem_req          <= 1'b0;
            refill_just_done <= 1'b1;
            state            <= IDLE;
          end
        end
        WRITE: begin
          if (flush)
            flush_pend <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (flush)
            flush_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl: refill, hit, conflict miss, write-through
// hit/miss, flush deferred during refill, counter saturation, reset mid-WRITE.
module tb_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks;
  int errors;
  logic [15:0] exp_hit;
  logic [15:0] exp_miss;

  cache_ctrl #(.SET_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and move 1 ns past it; inputs change and outputs are
  // sampled there, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
    cpu_wdata = 32'h0; flush = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
    exp_hit = 16'h0; exp_miss = 16'h0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_counters got=%h/%h exp=0/0", hit_cnt, miss_cnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_miss();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL miss_req_stall got=%b exp=1", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL miss_rdata_zero got=%h exp=0", cpu_rdata); end
    tick();
    exp_miss = 16'd1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL refill_req got=%b/%b exp=1/0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL refill_addr got=%h exp=40", mem_addr); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL miss_cnt_1 got=%0d exp=%0d", miss_cnt, exp_miss); end
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || cpu_stall !== 1'b1) begin errors++; $display("FAIL refill_stable got=%b/%h/%b exp=1/40/1", mem_req, mem_addr, cpu_stall); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL refill_req_drop got=%b exp=0", mem_req); end
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL replay_hit got=%b/%h exp=0/deadbeef", cpu_stall, cpu_rdata); end
    tick();
    checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'd1) begin errors++; $display("FAIL replay_counts got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
    cpu_req = 1'b0;
    tick();
  endtask

  // Issue a load miss that is expected to go to REFILL, ack it with data and
  // let the replay retire.
  task automatic do_refill(input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL refill_miss_stall addr=%h got=%b exp=1", addr, cpu_stall); end
    tick();
    exp_miss++;
    checks++; if (miss_cnt !== exp_miss || mem_addr !== addr) begin errors++; $display("FAIL refill_start addr=%h got=%0d/%h exp=%0d/%h", addr, miss_cnt, mem_addr, exp_miss, addr); end
    mem_ack = 1'b1; mem_rdata = data;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (cpu_rdata !== data || cpu_stall !== 1'b0) begin errors++; $display("FAIL refill_replay addr=%h got=%h/%b exp=%h/0", addr, cpu_rdata, cpu_stall, data); end
    tick();
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_hit_and_conflict();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_40 got=%b/%h exp=0/deadbeef", cpu_stall, cpu_rdata); end
    tick();
    exp_hit = 16'd1;
    checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL hit_cnt_1 got=%0d exp=%0d", hit_cnt, exp_hit); end
    cpu_req = 1'b0;
    tick();
    do_refill(32'h60, 32'hCAFE_F00D);
    do_refill(32'h40, 32'hDEAD_BEEF);
    checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL hit_cnt_after_conflict got=%0d exp=%0d", hit_cnt, exp_hit); end
  endtask

  task automatic test_store_hit();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL store_req_stall got=%b exp=1", cpu_stall); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h40) begin errors++; $display("FAIL write_req got=%b/%b/%h/%h exp=1/1/12345678/40", mem_req, mem_we, mem_wdata, mem_addr); end
    tick();
    checks++; if (cpu_stall !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL write_wait got=%b/%b exp=1/1", cpu_stall, mem_req); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done got=%b/%b exp=0/0", cpu_stall, mem_req); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL load_after_store got=%b/%h exp=0/12345678", cpu_stall, cpu_rdata); end
    tick();
    exp_hit++;
    checks++; if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin errors++; $display("FAIL store_counts got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_store_miss();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h84; cpu_wdata = 32'hA5A5_A5A5;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h84 || mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL store_miss_write got=%b/%h/%h exp=1/84/a5a5a5a5", mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h84;
    #1;
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL no_allocate_rdata got=%h exp=0", cpu_rdata); end
    cpu_req = 1'b0;
    do_refill(32'h84, 32'h1111_2222);
  endtask

  task automatic test_flush_during_refill();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h88;
    tick();
    exp_miss++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL flush_pend_stall got=%b exp=1", cpu_stall); end
    tick();
    checks++; if (cpu_stall !== 1'b1 || cpu_rdata !== 32'h0 || miss_cnt !== exp_miss) begin errors++; $display("FAIL after_flush_miss got=%b/%h/%0d exp=1/0/%0d", cpu_stall, cpu_rdata, miss_cnt, exp_miss); end
    tick();
    exp_miss++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h88 || miss_cnt !== exp_miss) begin errors++; $display("FAIL flush_rerefill got=%b/%h/%0d exp=1/88/%0d", mem_req, mem_addr, miss_cnt, exp_miss); end
    mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL flushed_line_40 got=%b exp=1", cpu_stall); end
    cpu_req = 1'b0;
    do_refill(32'h40, 32'h1234_5678);
  endtask

  task automatic test_saturation();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h88;
    #1;
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL sat_hit got=%b/%h exp=0/55aa55aa", cpu_stall, cpu_rdata); end
    while (exp_hit != 16'hFFFF) begin
      tick();
      exp_hit++;
    end
    checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL hit_cnt_max got=%h exp=ffff", hit_cnt); end
    tick(); tick();
    checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL hit_cnt_saturate got=%h exp=ffff", hit_cnt); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h9999_9999;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL pre_reset_write got=%b/%b exp=1/1", mem_req, mem_we); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin errors++; $display("FAIL async_reset got=%b/%b/%h/%h exp=0/0/0/0", mem_req, mem_we, hit_cnt, miss_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_hit = 16'h0; exp_miss = 16'h0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL post_reset_invalid got=%b exp=1", cpu_stall); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || miss_cnt !== 16'd1) begin errors++; $display("FAIL post_reset_idle got=%b/%b/%0d exp=1/0/1", mem_req, mem_we, miss_cnt); end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    tick();
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_miss();
    test_hit_and_conflict();
    test_store_hit();
    test_store_miss();
    test_flush_during_refill();
    test_saturation();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
